// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory port controller: device registers at xFE00-xFFFF, everything else forwarded to RAM.
// Optional macro LC3_MCR_EN adds the machine control register at xFFFE and drives halt.
module lc3_mem_ctrl #(
    parameter int RAM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_en,
    input  logic        we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_rdy,
    output logic        ram_en,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic        halt
);
    // state    | meaning
    // IDLE     | waiting for mem_en
    // RAM_WAIT | RAM access in flight, lat_cnt counting down to terminal count
    // DONE     | one-cycle mem_rdy pulse
    typedef enum logic [1:0] {IDLE, RAM_WAIT, DONE} state_t;

    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;
    localparam logic [2:0]  LAT_LOAD  = 3'(RAM_LAT);

    if (RAM_LAT < 1 || RAM_LAT > 7) begin : g_bad_lat
        $error("lc3_mem_ctrl: RAM_LAT must be in 1..7");
    end

    state_t      state, state_nxt;
    logic [2:0]  lat_cnt;
    logic        we_q;
    logic        kb_full;
    logic [7:0]  kbuf;
    logic        start, is_dev, dev_acc, ram_acc, lat_tc;
    logic        kbdr_rd, ddr_wr;
    logic [15:0] dev_rdata;

`ifdef LC3_MCR_EN
    localparam logic [15:0] ADDR_MCR = 16'hFFFE;
    logic [15:0] mcr;
`endif

    assign start    = (state == IDLE) && mem_en;
    assign is_dev   = (mem_addr[15:9] == 7'h7F);
    assign dev_acc  = start && is_dev;
    assign ram_acc  = start && !is_dev;
    assign lat_tc   = (lat_cnt == 3'd1);
    assign kbdr_rd  = dev_acc && !we && (mem_addr == ADDR_KBDR);
    assign ddr_wr   = dev_acc && we && (mem_addr == ADDR_DDR);
    assign kb_ready = ~kb_full;

    always_comb begin
        dev_rdata = 16'h0000;
        case (mem_addr)
            ADDR_KBSR: dev_rdata = {kb_full, 15'b0};
            ADDR_KBDR: dev_rdata = {8'h00, kbuf};
            ADDR_DSR:  dev_rdata = {~disp_valid, 15'b0};
            ADDR_DDR:  dev_rdata = {8'h00, disp_data};
`ifdef LC3_MCR_EN
            ADDR_MCR:  dev_rdata = mcr;
`endif
            default:   dev_rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_rdy   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_en) begin
                    state_nxt = is_dev ? DONE : RAM_WAIT;
                end
            end
            RAM_WAIT: begin
                if (lat_tc) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                mem_rdy   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The counter hits zero on the same edge that captures the RAM data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= 16'h0000;
            ram_wdata <= 16'h0000;
            we_q      <= 1'b0;
            lat_cnt   <= 3'd0;
        end else begin
            ram_en <= ram_acc;
            ram_we <= ram_acc && we;
            if (ram_acc) begin
                ram_addr  <= mem_addr;
                ram_wdata <= mem_wdata;
                we_q      <= we;
                lat_cnt   <= LAT_LOAD;
            end else if (state == RAM_WAIT) begin
                lat_cnt <= lat_cnt - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_rdata <= 16'h0000;
        end else if (dev_acc && !we) begin
            mem_rdata <= dev_rdata;
        end else if ((state == RAM_WAIT) && lat_tc && !we_q) begin
            mem_rdata <= ram_rdata;
        end
    end

    // A KBDR clear cannot coincide with an accept: accept needs kb_full low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kb_full <= 1'b0;
            kbuf    <= 8'h00;
        end else if (kb_valid && !kb_full) begin
            kbuf    <= kb_data;
            kb_full <= 1'b1;
        end else if (kbdr_rd) begin
            kb_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_valid <= 1'b0;
            disp_data  <= 8'h00;
        end else if (ddr_wr && !disp_valid) begin
            disp_data  <= mem_wdata[7:0];
            disp_valid <= 1'b1;
        end else if (disp_ready) begin
            disp_valid <= 1'b0;
        end
    end

`ifdef LC3_MCR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcr <= 16'h8000;
        end else if (dev_acc && we && (mem_addr == ADDR_MCR)) begin
            mcr <= mem_wdata;
        end
    end

    assign halt = ~mcr[15];
`else
    assign halt = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl: directed literal checks plus randomized traffic
// compared every cycle against a transaction-level schedule model.
module tb_lc3_mem_ctrl;
    localparam int RAM_LAT = 2;
    localparam int PIDX    = (RAM_LAT >= 2) ? RAM_LAT - 2 : 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_en = 1'b0;
    logic        we = 1'b0;
    logic [15:0] mem_addr = 16'h0;
    logic [15:0] mem_wdata = 16'h0;
    logic [15:0] mem_rdata;
    logic        mem_rdy;
    logic        ram_en, ram_we;
    logic [15:0] ram_addr, ram_wdata, ram_rdata;
    logic        kb_valid = 1'b0;
    logic [7:0]  kb_data = 8'h0;
    logic        kb_ready;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ready = 1'b0;
    logic        halt;

    lc3_mem_ctrl #(.RAM_LAT(RAM_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .mem_en(mem_en), .we(we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .kb_valid(kb_valid), .kb_data(kb_data), .kb_ready(kb_ready),
        .disp_valid(disp_valid), .disp_data(disp_data), .disp_ready(disp_ready), .halt(halt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic int ram_idx(input logic [15:0] a);
        return int'({(a[15:12] == 4'hF), a[3:0]});
    endfunction

    // RAM behind the controller; data is valid only in the cycle it is due.
    logic [15:0] tb_ram [0:31] = '{default: 16'h0000};
    logic [15:0] pipe   [0:7]  = '{default: 16'h0000};
    always @(posedge clk) begin
        for (int i = 7; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= (ram_en && !ram_we) ? tb_ram[ram_idx(ram_addr)] : 16'($urandom);
        if (ram_en && ram_we) tb_ram[ram_idx(ram_addr)] <= ram_wdata;
    end
    assign ram_rdata = (RAM_LAT == 1) ? tb_ram[ram_idx(ram_addr)] : pipe[PIDX];

    // Reference model: per-edge effects and completion times as plain schedule arithmetic.
    int          cyc = 0;
    int          idle_from = 0;
    int          m_rdy_at = -1;
    int          m_ram_en_at = -1;
    bit          m_kb_full = 0, m_disp_valid = 0, m_pend_rd = 0, m_ram_we = 0;
    logic [7:0]  m_kbuf = 8'h0, m_disp_data = 8'h0;
    logic [15:0] m_rdata = 16'h0, m_pend_val = 16'h0, m_ram_addr = 16'h0, m_ram_wdata = 16'h0;
    logic [15:0] m_mcr = 16'h8000;
    logic [15:0] m_ram [0:31] = '{default: 16'h0000};

    always @(posedge clk) begin : model
        logic [15:0] rv;
        bit acc, dev, kbdr_rd, ddr_wr;
        cyc++;
        if (!rst_n) begin
            m_kb_full = 0; m_kbuf = 8'h0; m_disp_valid = 0; m_disp_data = 8'h0;
            m_rdata = 16'h0; m_pend_rd = 0; m_mcr = 16'h8000;
            m_rdy_at = -1; m_ram_en_at = -1; idle_from = cyc + 1;
        end else begin
            acc = mem_en && (cyc >= idle_from);
            dev = acc && (mem_addr >= 16'hFE00);
            rv = 16'h0000;
            if (dev && !we) begin
                if (mem_addr == 16'hFE00) rv = m_kb_full ? 16'h8000 : 16'h0000;
                if (mem_addr == 16'hFE02) rv = {8'h00, m_kbuf};
                if (mem_addr == 16'hFE04) rv = m_disp_valid ? 16'h0000 : 16'h8000;
                if (mem_addr == 16'hFE06) rv = {8'h00, m_disp_data};
`ifdef LC3_MCR_EN
                if (mem_addr == 16'hFFFE) rv = m_mcr;
`endif
            end
            kbdr_rd = dev && !we && (mem_addr == 16'hFE02);
            ddr_wr  = dev && we && (mem_addr == 16'hFE06);
            if (kb_valid && !m_kb_full) begin
                m_kbuf = kb_data; m_kb_full = 1;
            end else if (kbdr_rd) m_kb_full = 0;
            if (ddr_wr && !m_disp_valid) begin
                m_disp_data = mem_wdata[7:0]; m_disp_valid = 1;
            end else if (disp_ready) m_disp_valid = 0;
            if (dev && we && (mem_addr == 16'hFFFE)) m_mcr = mem_wdata;
            if (acc) begin
                if (dev) begin
                    m_rdy_at = cyc;
                    if (!we) m_rdata = rv;
                end else begin
                    m_rdy_at = cyc + RAM_LAT;
                    m_ram_en_at = cyc;
                    m_ram_we = we; m_ram_addr = mem_addr; m_ram_wdata = mem_wdata;
                    m_pend_rd = !we;
                    if (we) m_ram[ram_idx(mem_addr)] = mem_wdata;
                    else m_pend_val = m_ram[ram_idx(mem_addr)];
                end
                idle_from = m_rdy_at + 2;
            end
            if (m_pend_rd && cyc == m_rdy_at) begin
                m_rdata = m_pend_val; m_pend_rd = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            chk("mem_rdy", mem_rdy, cyc == m_rdy_at);
            chk("mem_rdata", mem_rdata, m_rdata);
            chk("ram_en", ram_en, cyc == m_ram_en_at);
            if (cyc == m_ram_en_at) begin
                chk("ram_we", ram_we, m_ram_we);
                chk("ram_addr", ram_addr, m_ram_addr);
                chk("ram_wdata", ram_wdata, m_ram_wdata);
            end
            chk("kb_ready", kb_ready, !m_kb_full);
            chk("disp_valid", disp_valid, m_disp_valid);
            chk("disp_data", disp_data, m_disp_data);
`ifdef LC3_MCR_EN
            chk("halt", halt, ~m_mcr[15]);
`else
            chk("halt", halt, 1'b0);
`endif
        end
    end

    task automatic rand_periph();
        kb_valid   = ($urandom % 4) == 0;
        kb_data    = 8'($urandom);
        disp_ready = ($urandom % 3) == 0;
    endtask

    // Called right after a negedge; returns after the controller is back in IDLE.
    task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input bit junk, output logic [15:0] rd, output int lat,
                          output int pulses, output bit aborted);
        mem_en = 1'b1; we = w; mem_addr = a; mem_wdata = d;
        @(negedge clk);
        mem_en = 1'b0;
        lat = 0; pulses = 0; aborted = 0; rd = 16'h0;
        for (int n = 1; n <= 20; n++) begin
            if (ram_en) pulses++;
            if (mem_rdy) begin
                lat = n; rd = mem_rdata;
                break;
            end
            if (junk) begin
                rand_periph();
                if (($urandom % 30) == 0) begin
                    rst_n = 1'b0; mem_en = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1; aborted = 1;
                    break;
                end
                mem_en = $urandom % 2; we = $urandom % 2;
                mem_addr = 16'($urandom); mem_wdata = 16'($urandom);
            end
            @(negedge clk);
        end
        mem_en = 1'b0;
        if (lat == 0 && !aborted) begin
            n_chk++;
            $display("FAIL rdy_timeout: no mem_rdy within 20 cycles for addr %h", a);
        end
        if (junk) rand_periph();
        @(negedge clk);
    endtask

    task automatic do_rd(input logic [15:0] a, input logic [15:0] exp_d, input int exp_lat,
                         input string nm);
        logic [15:0] rd; int lat, p; bit ab;
        access(1'b0, a, 16'h0, 1'b0, rd, lat, p, ab);
        chk({nm, "_data"}, rd, exp_d);
        chk({nm, "_lat"}, lat, exp_lat);
        chk({nm, "_ram_en_pulses"}, p, (exp_lat == 1) ? 0 : 1);
    endtask

    task automatic do_wr(input logic [15:0] a, input logic [15:0] d, input int exp_lat,
                         input string nm);
        logic [15:0] rd; int lat, p; bit ab;
        access(1'b1, a, d, 1'b0, rd, lat, p, ab);
        chk({nm, "_lat"}, lat, exp_lat);
        chk({nm, "_ram_en_pulses"}, p, (exp_lat == 1) ? 0 : 1);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_mem_rdy"}, mem_rdy, 1'b0);
        chk({nm, "_mem_rdata"}, mem_rdata, 16'h0000);
        chk({nm, "_ram_en"}, ram_en, 1'b0);
        chk({nm, "_ram_we"}, ram_we, 1'b0);
        chk({nm, "_ram_addr"}, ram_addr, 16'h0000);
        chk({nm, "_ram_wdata"}, ram_wdata, 16'h0000);
        chk({nm, "_kb_ready"}, kb_ready, 1'b1);
        chk({nm, "_disp_valid"}, disp_valid, 1'b0);
        chk({nm, "_disp_data"}, disp_data, 8'h00);
        chk({nm, "_halt"}, halt, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_seen, sel;
        logic [15:0] a, rd;
        int lat, p;
        bit ab, w;

        rst_n = 1'b0;
        @(negedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        do_wr(16'h3000, 16'h1234, RAM_LAT + 1, "ram_wr");
        do_rd(16'h3000, 16'h1234, RAM_LAT + 1, "ram_rd");
        do_wr(16'hFDFF, 16'hBEEF, RAM_LAT + 1, "ram_wr_top");
        do_rd(16'hFDFF, 16'hBEEF, RAM_LAT + 1, "ram_rd_top");

        kb_valid = 1'b1; kb_data = 8'h41;
        @(negedge clk);
        kb_valid = 1'b0; kb_data = 8'h00;
        chk("kb_ready_low", kb_ready, 1'b0);
        do_rd(16'hFE00, 16'h8000, 1, "kbsr_full");
        do_rd(16'hFE02, 16'h0041, 1, "kbdr");
        do_rd(16'hFE00, 16'h0000, 1, "kbsr_empty");
        chk("kb_ready_high", kb_ready, 1'b1);
        do_rd(16'hFE02, 16'h0041, 1, "kbdr_stale");

        disp_ready = 1'b0;
        do_wr(16'hFE06, 16'h0058, 1, "ddr_wr");
        chk("disp_valid_set", disp_valid, 1'b1);
        chk("disp_data_58", disp_data, 8'h58);
        do_rd(16'hFE04, 16'h0000, 1, "dsr_busy");
        do_wr(16'hFE06, 16'h0059, 1, "ddr_wr_drop");
        chk("disp_data_kept", disp_data, 8'h58);
        disp_ready = 1'b1;
        @(negedge clk);
        disp_ready = 1'b0;
        chk("disp_valid_clr", disp_valid, 1'b0);
        do_rd(16'hFE04, 16'h8000, 1, "dsr_ready");
        do_rd(16'hFE06, 16'h0058, 1, "ddr_rd");

        do_rd(16'hFE10, 16'h0000, 1, "unmapped_rd");
        do_wr(16'hFE10, 16'hFFFF, 1, "unmapped_wr");
        do_wr(16'hFE00, 16'hFFFF, 1, "kbsr_wr");
        do_rd(16'hFE00, 16'h0000, 1, "kbsr_after_wr");

        // Give reset something to clear, then reset mid RAM access.
        do_wr(16'hFE06, 16'h005A, 1, "ddr_wr2");
        kb_valid = 1'b1; kb_data = 8'h7E;
        @(negedge clk);
        kb_valid = 1'b0;
        mem_en = 1'b1; we = 1'b0; mem_addr = 16'h3000;
        @(negedge clk);
        mem_en = 1'b0;
        chk("rst_test_ram_en", ram_en, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("mid_reset");
        rst_n = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (mem_rdy) rdy_seen++;
            @(negedge clk);
        end
        chk("no_rdy_after_reset", rdy_seen, 0);
        do_rd(16'h3000, 16'h1234, RAM_LAT + 1, "post_reset_rd");

`ifdef LC3_MCR_EN
        do_rd(16'hFFFE, 16'h8000, 1, "mcr_rd");
        chk("mcr_halt0", halt, 1'b0);
        do_wr(16'hFFFE, 16'h0000, 1, "mcr_wr");
        chk("mcr_halt1", halt, 1'b1);
        do_rd(16'hFFFE, 16'h0000, 1, "mcr_rd0");
        do_wr(16'hFFFE, 16'h8000, 1, "mcr_restore");
        chk("mcr_halt_clr", halt, 1'b0);
`else
        do_rd(16'hFFFE, 16'h0000, 1, "mcr_unmapped");
        do_wr(16'hFFFE, 16'h0000, 1, "mcr_wr_ignored");
        chk("halt_tied", halt, 1'b0);
`endif

        for (int k = 0; k < 400; k++) begin
            sel = $urandom % 10;
            w = $urandom % 2;
            case (sel)
                0, 1, 2, 3, 4: a = (($urandom % 2) == 0 ? 16'h3000 : 16'hFDF0) | 16'($urandom % 16);
                5: a = 16'hFE00;
                6: a = 16'hFE02;
                7: a = 16'hFE04;
                8: a = 16'hFE06;
                default: a = (($urandom % 2) == 0) ? 16'hFFFE : (16'hFE00 | 16'($urandom % 512));
            endcase
            rand_periph();
            access(w, a, 16'($urandom), 1'b1, rd, lat, p, ab);
            if (!ab) chk("rnd_lat", lat, (a >= 16'hFE00) ? 1 : RAM_LAT + 1);
        end
        kb_valid = 1'b0; disp_ready = 1'b0; mem_en = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
